// File: rtl/duc_model_path_pkg.sv
// Shared types and constants for the DUC model path-sanitise stream.
// Mode, FSM state, default delimiter and the lane-count legality check.
package duc_model_path_pkg;

    typedef enum logic {
        PATH_CUT_FIRST = 1'b0,
        PATH_CUT_LAST  = 1'b1
    } path_mode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        EMIT    = 2'd2
    } path_state_t;

    localparam logic [7:0] DELIM_DEFAULT = 8'h2F;

    // Bit n set means a beat width of n lanes is supported (1, 2, 4, 8).
    localparam logic [8:0] LANES_LEGAL_MASK = 9'b1_0001_0110;

    function automatic bit lanes_legal(input int unsigned n);
        return (n < 9) && LANES_LEGAL_MASK[n[3:0]];
    endfunction

endpackage

// File: rtl/duc_model_path_delim_find.sv
// Per-beat delimiter search over kept lanes; purely combinational, zero latency.
// Reports whether any kept lane matches plus the lowest and highest matching lane.
module duc_model_path_delim_find #(
    parameter int LANES = 4,
    parameter int LW    = 2
) (
    input  logic [8*LANES-1:0] data,
    input  logic [LANES-1:0]   keep,
    input  logic [7:0]         delim,
    output logic               any_hit,
    output logic [LW-1:0]      first_lane,
    output logic [LW-1:0]      last_lane
);

    logic [LANES-1:0] hit;

    always_comb begin
        hit = '0;
        for (int l = 0; l < LANES; l++) begin
            hit[l] = keep[l] && (data[8*l +: 8] == delim);
        end
    end

    // Descending scan leaves the lowest hit; ascending scan leaves the highest.
    always_comb begin
        first_lane = '0;
        last_lane  = '0;
        for (int l = LANES - 1; l >= 0; l--) begin
            if (hit[l]) first_lane = LW'(l);
        end
        for (int l = 0; l < LANES; l++) begin
            if (hit[l]) last_lane = LW'(l);
        end
    end

    assign any_hit = |hit;

endmodule

// File: rtl/duc_model_path_sanitize_stream.sv
// Store-and-forward path sanitiser: zeroes every byte from the first/last delimiter on.
// First output beat 1 cycle after the last input beat; s_ready drops for the whole emit phase.
module duc_model_path_sanitize_stream
    import duc_model_path_pkg::*;
#(
    parameter int LANES     = 4,
    parameter int MAX_BYTES = 512,
    parameter int CUT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic               clk,
    input  logic               areset_n,
    input  logic [7:0]         cfg_delim,
    input  logic               cfg_mode,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [8*LANES-1:0] s_data,
    input  logic [LANES-1:0]   s_keep,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [8*LANES-1:0] m_data,
    output logic [LANES-1:0]   m_keep,
    output logic               m_last,
    output logic               m_found,
    output logic [CUT_W-1:0]   m_cut,
    output logic               m_err
);

    localparam int BEATS = MAX_BYTES / LANES;
    localparam int BCW   = $clog2(BEATS + 1);
    localparam int PW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;

    if (!lanes_legal(LANES) || (MAX_BYTES % LANES) != 0) begin : g_bad_cfg
        $error("duc_model_path_sanitize_stream: illegal LANES/MAX_BYTES combination");
    end

    logic [8*LANES-1:0] buf_dat  [BEATS];
    logic [LANES-1:0]   buf_keep [BEATS];

    path_state_t state, state_nxt;
    logic        rst_done;
    logic [BCW-1:0]   beat_cnt;
    logic [CUT_W-1:0] byte_cnt;
    logic             first_set;
    logic [CUT_W-1:0] first_idx;
    logic [CUT_W-1:0] last_idx;
    logic             ovf;
    logic [7:0]       delim_q;
    path_mode_t       mode_q;
    logic [PW-1:0]    rd_ptr;
    logic [CUT_W-1:0] cut_q;
    logic             found_q;
    logic             err_q;

    logic             s_fire, m_fire, store_ok, hit;
    logic [7:0]       delim_sel;
    path_mode_t       mode_sel;
    logic             any_hit;
    logic [LW-1:0]    first_lane, last_lane;
    logic [CUT_W-1:0] base, kcnt, byte_nxt;
    logic [CUT_W-1:0] first_idx_nxt, last_idx_nxt, cut_nxt, rd_base;
    logic             first_set_nxt, ovf_nxt;

    assign s_ready  = rst_done && (state != EMIT);
    assign m_valid  = (state == EMIT);
    assign m_last   = (state == EMIT) && ((BCW'(rd_ptr) + BCW'(1)) == beat_cnt);
    assign s_fire   = s_valid && s_ready;
    assign m_fire   = m_valid && m_ready;
    assign store_ok = beat_cnt < BCW'(BEATS);
    assign m_found  = found_q;
    assign m_cut    = cut_q;
    assign m_err    = err_q;

    // The opening beat must see the live config; later beats use the latched copy.
    assign delim_sel = (state == IDLE) ? cfg_delim : delim_q;
    assign mode_sel  = (state == IDLE) ? path_mode_t'(cfg_mode) : mode_q;

    duc_model_path_delim_find #(
        .LANES (LANES),
        .LW    (LW)
    ) u_find (
        .data       (s_data),
        .keep       (s_keep),
        .delim      (delim_sel),
        .any_hit    (any_hit),
        .first_lane (first_lane),
        .last_lane  (last_lane)
    );

    always_comb begin
        base = CUT_W'(beat_cnt) * CUT_W'(LANES);
        kcnt = '0;
        for (int l = 0; l < LANES; l++) begin
            kcnt = kcnt + CUT_W'(s_keep[l]);
        end
        hit           = store_ok && any_hit;
        byte_nxt      = store_ok ? (byte_cnt + kcnt) : byte_cnt;
        first_set_nxt = first_set || hit;
        first_idx_nxt = (first_set || !hit) ? first_idx : (base + CUT_W'(first_lane));
        last_idx_nxt  = hit ? (base + CUT_W'(last_lane)) : last_idx;
        ovf_nxt       = ovf || !store_ok;
        if (!first_set_nxt) begin
            cut_nxt = byte_nxt;
        end else if (mode_sel == PATH_CUT_LAST) begin
            cut_nxt = last_idx_nxt;
        end else begin
            cut_nxt = first_idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s_fire) state_nxt = s_last ? EMIT : CAPTURE;
            CAPTURE: if (s_fire && s_last) state_nxt = EMIT;
            EMIT:    if (m_fire && m_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Packet storage carries no reset: every location read is written first.
    always_ff @(posedge clk) begin
        if (s_fire && store_ok) begin
            buf_dat[PW'(beat_cnt)]  <= s_data;
            buf_keep[PW'(beat_cnt)] <= s_keep;
        end
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            rst_done  <= 1'b0;
            beat_cnt  <= '0;
            byte_cnt  <= '0;
            first_set <= 1'b0;
            first_idx <= '0;
            last_idx  <= '0;
            ovf       <= 1'b0;
            delim_q   <= DELIM_DEFAULT;
            mode_q    <= PATH_CUT_FIRST;
            rd_ptr    <= '0;
            cut_q     <= '0;
            found_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
            if (s_fire) begin
                if (state == IDLE) begin
                    delim_q <= cfg_delim;
                    mode_q  <= path_mode_t'(cfg_mode);
                end
                if (store_ok) beat_cnt <= beat_cnt + BCW'(1);
                byte_cnt  <= byte_nxt;
                first_set <= first_set_nxt;
                first_idx <= first_idx_nxt;
                last_idx  <= last_idx_nxt;
                ovf       <= ovf_nxt;
                if (s_last) begin
                    cut_q   <= cut_nxt;
                    found_q <= first_set_nxt;
                    err_q   <= ovf_nxt;
                end
            end
            if (m_fire) begin
                if (m_last) begin
                    rd_ptr    <= '0;
                    beat_cnt  <= '0;
                    byte_cnt  <= '0;
                    first_set <= 1'b0;
                    first_idx <= '0;
                    last_idx  <= '0;
                    ovf       <= 1'b0;
                end else begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
            end
        end
    end

    always_comb begin
        m_data  = '0;
        m_keep  = '0;
        rd_base = CUT_W'(rd_ptr) * CUT_W'(LANES);
        if (state == EMIT) begin
            m_keep = buf_keep[rd_ptr];
            for (int l = 0; l < LANES; l++) begin
                if ((rd_base + CUT_W'(l)) < cut_q) m_data[8*l +: 8] = buf_dat[rd_ptr][8*l +: 8];
            end
        end
    end

endmodule

// File: tb/tb_duc_model_path_sanitize_stream.sv
// Scoreboard bench for duc_model_path_sanitize_stream with LANES=4, MAX_BYTES=16.
// Stimulus pushes expected output beats; an independent monitor pops and compares.
module tb_duc_model_path_sanitize_stream;

    logic        clk;
    logic        areset_n;
    logic [7:0]  cfg_delim;
    logic        cfg_mode;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_keep;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;
    logic        m_found;
    logic [4:0]  m_cut;
    logic        m_err;

    duc_model_path_sanitize_stream #(
        .LANES     (4),
        .MAX_BYTES (16)
    ) dut (
        .clk       (clk),
        .areset_n  (areset_n),
        .cfg_delim (cfg_delim),
        .cfg_mode  (cfg_mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_keep    (s_keep),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_keep    (m_keep),
        .m_last    (m_last),
        .m_found   (m_found),
        .m_cut     (m_cut),
        .m_err     (m_err)
    );

    typedef struct {
        logic [31:0] dat;
        logic [3:0]  keep;
        logic        last;
        logic        found;
        logic [4:0]  cut;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l,
                        input logic f, input logic [4:0] c, input logic e);
        exp_t x;
        x.dat = d; x.keep = k; x.last = l; x.found = f; x.cut = c; x.err = e;
        sb.push_back(x);
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_keep  = k;
        s_last  = l;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) fail_now("s_handshake_timeout");
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            fail_now("drain_timeout");
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every accepted output beat, plus hold/stall properties.
    logic        stall_prev = 1'b0;
    logic [31:0] prev_dat;
    logic        prev_last;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (areset_n && m_valid) begin
                check("s_ready_low_in_emit", s_ready, 1'b0);
                if (stall_prev) begin
                    check("stall_data_hold", m_data, prev_dat);
                    check("stall_last_hold", m_last, prev_last);
                end
                if (m_ready) begin
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_beat: got data %h, expected no beat", m_data);
                    end else begin
                        e = sb.pop_front();
                        check("m_data", m_data, e.dat);
                        check("m_keep", m_keep, e.keep);
                        check("m_last", m_last, e.last);
                        if (e.last) begin
                            check("m_found", m_found, e.found);
                            check("m_cut", m_cut, e.cut);
                            check("m_err", m_err, e.err);
                        end
                    end
                end
                stall_prev = !m_ready;
                prev_dat   = m_data;
                prev_last  = m_last;
            end else begin
                stall_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        areset_n  = 1'b0;
        cfg_delim = 8'h2F;
        cfg_mode  = 1'b0;
        s_valid   = 1'b0;
        s_data    = '0;
        s_keep    = '0;
        s_last    = 1'b0;
        m_ready   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s_ready", s_ready, 1'b0);
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_found", m_found, 1'b0);
        check("rst_m_err", m_err, 1'b0);
        check("rst_m_cut", m_cut, 5'd0);
        check("rst_m_data", m_data, 32'h0);
        check("rst_m_keep", m_keep, 4'h0);
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_s_ready", s_ready, 1'b1);

        // 1: FIRST '/', "ab/c" "d/ef"
        cfg_delim = 8'h2F;
        cfg_mode  = 1'b0;
        push(32'h00006261, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0);
        push(32'h00000000, 4'hF, 1'b1, 1'b1, 5'd2, 1'b0);
        send(32'h632F6261, 4'hF, 1'b0);
        send(32'h66652F64, 4'hF, 1'b1);
        drain();

        // 2: LAST '/', same string; delim changed mid-packet must be ignored
        cfg_mode = 1'b1;
        push(32'h632F6261, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0);
        push(32'h00000064, 4'hF, 1'b1, 1'b1, 5'd5, 1'b0);
        send(32'h632F6261, 4'hF, 1'b0);
        cfg_delim = 8'h61;
        check("t2_m_valid_before_last", m_valid, 1'b0);
        send(32'h66652F64, 4'hF, 1'b1);
        check("t2_latency_m_valid", m_valid, 1'b1);

        // 3: no delimiter, issued while the previous packet is still emitting
        cfg_delim = 8'h2F;
        cfg_mode  = 1'b0;
        push(32'h64636261, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0);
        push(32'h00006665, 4'h3, 1'b1, 1'b0, 5'd6, 1'b0);
        send(32'h64636261, 4'hF, 1'b0);
        send(32'h7A7A6665, 4'h3, 1'b1);
        drain();

        // 4: overflow, 5 beats into a 4-beat buffer
        for (int i = 0; i < 4; i++) push(32'h78787878, 4'hF, (i == 3), 1'b0, 5'd16, 1'b1);
        for (int i = 0; i < 5; i++) begin
            check("ovf_s_ready", s_ready, 1'b1);
            send(32'h78787878, 4'hF, (i == 4));
        end
        drain();

        // 5: backpressure pattern during emit, '.' at index 10
        cfg_delim = 8'h2E;
        push(32'h64636261, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0);
        push(32'h68676665, 4'hF, 1'b0, 1'b0, 5'd0, 1'b0);
        push(32'h00006A69, 4'hF, 1'b1, 1'b1, 5'd10, 1'b0);
        send(32'h64636261, 4'hF, 1'b0);
        send(32'h68676665, 4'hF, 1'b0);
        send(32'h6B2E6A69, 4'hF, 1'b1);
        for (int k = 0; k < 6; k++) begin
            m_ready = (k == 1 || k == 2 || k == 4) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        m_ready = 1'b1;
        drain();

        // 6: reset mid-packet, then "/zzz" in FIRST mode
        cfg_delim = 8'h2F;
        cfg_mode  = 1'b0;
        send(32'h64636261, 4'hF, 1'b0);
        send(32'h68676665, 4'hF, 1'b0);
        areset_n = 1'b0;
        #2;
        check("midrst_s_ready", s_ready, 1'b0);
        check("midrst_m_valid", m_valid, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        areset_n = 1'b1;
        @(posedge clk);
        #1;
        push(32'h00000000, 4'hF, 1'b1, 1'b1, 5'd0, 1'b0);
        send(32'h7A7A7A2F, 4'hF, 1'b1);
        drain();

        // 7: delimiter only in unkept lanes is not a match
        push(32'h00006261, 4'h3, 1'b1, 1'b0, 5'd2, 1'b0);
        send(32'h2F2F6261, 4'h3, 1'b1);
        drain();
        check("hold_m_valid_idle", m_valid, 1'b0);
        check("hold_m_cut", m_cut, 5'd2);
        check("hold_m_found", m_found, 1'b0);
        check("idle_s_ready_after", s_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
